telemetry_seq: RTL and testbench
================================

# telemetry_seq

Periodic telemetry packet sequencer sitting between the eBike sensor/A2D datapath and UART_tx. On each telemetry period it snapshots battery, current and torque readings and drives UART_tx through eight `trmt`/`tx_done` handshakes. The resulting 8-byte frame is AA, 55, BATT, CURR, TORQUE, with each 12-bit value sent high nibble first.

## Interface
- FAST_SIM, default 1, selects the telemetry period: 1 gives 4096 clk cycles, 0 gives 1048576 clk cycles.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  telemetry enable; sampled only on a period tick.
- batt  in  12  battery reading from the A2D interface.
- curr  in  12  motor current reading from the A2D interface.
- torque  in  12  pedal torque reading from the A2D interface.
- tx_done  in  1  one-cycle pulse from UART_tx when the current byte has finished shifting out.
- trmt  out  1  one-cycle start pulse to UART_tx.
- tx_data  out  8  byte presented to UART_tx.
- busy  out  1  high while a packet is in flight.
- pkt_done  out  1  one-cycle pulse after the final byte completes.

## Operation
- Period counter:
  - Free-running, 12 bits (FAST_SIM=1) or 20 bits (FAST_SIM=0).
  - A tick occurs when the counter is all ones. The counter then wraps to 0.
  - The counter runs regardless of `en` or state.
- Shadow registers: three 12-bit registers (sb, sc, st), loaded from batt/curr/torque only on a tick edge that starts a packet. All bytes of a packet come from one snapshot, so input changes mid-packet do not appear in that packet.
- Byte index `idx`, 3 bits:
  - 0: 8'hAA
  - 1: 8'h55
  - 2: {4'h0, sb[11:8]}
  - 3: sb[7:0]
  - 4: {4'h0, sc[11:8]}
  - 5: sc[7:0]
  - 6: {4'h0, st[11:8]}
  - 7: st[7:0]
- FSM states: IDLE, XMIT, WAIT.
  - IDLE: on tick with en=1, load the shadows, set idx=0, go to XMIT. Otherwise stay in IDLE.
  - XMIT: trmt=1 for this single cycle. Go to WAIT unconditionally. A tx_done seen in XMIT is ignored.
  - WAIT: hold until tx_done=1.
    - If idx≠7: increment idx and go to XMIT.
    - If idx=7: go to IDLE and pulse pkt_done.
- `busy` = (state≠IDLE).
- `tx_data` is a registered function of idx and the shadows. It is stable from the XMIT cycle until the tx_done that ends that byte.
- Boundary behaviour:
  - Tick while busy: dropped. No queuing, no shadow reload, and the in-flight packet is undisturbed.
  - en deasserted mid-packet: the packet completes all 8 bytes. en is only sampled at a tick.
  - tx_done while IDLE: ignored.
  - Tick in the same cycle pkt_done is asserted: state is IDLE at that edge, so a new packet starts. There is no dead cycle requirement.
  - rst asserted at any time, including mid-packet:
    - State returns to IDLE, idx=0 and the counter clears to 0 immediately.
    - The partial packet is abandoned. UART_tx may finish its current byte.

## Timing
- Reset values: trmt=0, tx_data=8'h00, busy=0, pkt_done=0, state=IDLE, counter=0, shadows=0.
- Period tick at counter value 2^N−1, where N is 12 or 20. With FAST_SIM=1, the first tick after reset release falls on the 4096th rising edge.
- Tick sampled at edge T: trmt is high in cycle T+1, with tx_data=8'hAA valid in the same cycle. busy rises in cycle T+1.
- tx_done sampled at edge D while in WAIT: the next trmt is high in cycle D+1 with the next byte already on tx_data.
- Final tx_done (idx=7) at edge D: in cycle D+1, pkt_done=1 and busy=0.
- Minimum packet length is 16 cycles, reached when tx_done arrives in the cycle immediately after each trmt.
- Exactly 8 trmt pulses per started packet. trmt is never high in two consecutive cycles.

## Test plan
- Reset and first packet:
  - Stimulus: FAST_SIM=1, en=1, batt=12'hABC, curr=12'h123, torque=12'h7F0, with a tx_done responder 3 cycles after each trmt.
  - Required: the first trmt comes 4096 cycles after reset release. Bytes are AA,55,0A,BC,01,23,07,F0. pkt_done is a single pulse and busy is low afterwards.
- Snapshot integrity: change batt to 12'h555 after byte 2 has been sent. Bytes 2–3 still read 0A,BC. The next period's packet carries 05,55.
- Enable gating:
  - en=0 at a tick: no trmt for the whole period.
  - en dropped after byte 1: all 8 bytes still sent, and no packet at the next tick.
- Overrun: hold tx_done off until after the next tick, then resume. The packet completes normally and no second packet starts from the dropped tick. The following tick starts a packet normally.
- Spurious handshakes:
  - tx_done pulsed in IDLE: no state change.
  - tx_done coincident with trmt: ignored, and the byte still waits for a later tx_done.
- Mid-packet reset: assert rst during WAIT at idx=4. All outputs return to reset values asynchronously. After release, the next packet starts at AA, 4096 cycles later.

Source files
------------

// File: rtl/telemetry_seq.sv
// Periodic telemetry sequencer: snapshots battery/current/torque on a period tick
// and walks UART_tx through an 8-byte AA,55,BATT,CURR,TORQUE frame.
module telemetry_seq #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] torque,
    input  logic        tx_done,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        pkt_done
);

    localparam int CNT_W = FAST_SIM ? 12 : 20;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, XMIT, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             load;
    logic             done_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [11:0]      sb, sc, st;
    logic [11:0]      sb_nxt, sc_nxt, st_nxt;

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [11:0] b,
                                              input logic [11:0] c, input logic [11:0] t);
        case (i)
            3'd0:    frame_byte = 8'hAA;
            3'd1:    frame_byte = 8'h55;
            3'd2:    frame_byte = {4'h0, b[11:8]};
            3'd3:    frame_byte = b[7:0];
            3'd4:    frame_byte = {4'h0, c[11:8]};
            3'd5:    frame_byte = c[7:0];
            3'd6:    frame_byte = {4'h0, t[11:8]};
            default: frame_byte = t[7:0];
        endcase
    endfunction

    // Free-running period counter; a tick is the all-ones value just before wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign tick = &cnt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (tick && en) begin
                    load      = 1'b1;
                    idx_nxt   = 3'd0;
                    state_nxt = XMIT;
                end
            end
            XMIT: state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (idx == 3'd7) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = XMIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadows only reload when a packet actually starts, so a dropped tick never disturbs them.
    assign sb_nxt = load ? batt   : sb;
    assign sc_nxt = load ? curr   : sc;
    assign st_nxt = load ? torque : st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            sb       <= '0;
            sc       <= '0;
            st       <= '0;
            tx_data  <= 8'h00;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            sb       <= sb_nxt;
            sc       <= sc_nxt;
            st       <= st_nxt;
            tx_data  <= frame_byte(idx_nxt, sb_nxt, sc_nxt, st_nxt);
            pkt_done <= done_nxt;
        end
    end

    assign trmt = (state == XMIT);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_telemetry_seq.sv
// Directed/randomized bench for telemetry_seq: frames are predicted from the
// snapshot values and tick positions derived from the cycle count since reset.
module tb_telemetry_seq;

    localparam int PERIOD = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] batt, curr, torque;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        pkt_done;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    int opt_dly, opt_spur, opt_batt, opt_en_drop, opt_hold_idx, opt_hold_edge, opt_rst;

    telemetry_seq #(.FAST_SIM(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .batt     (batt),
        .curr     (curr),
        .torque   (torque),
        .tx_done  (tx_done),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset release; ticks land on multiples of PERIOD.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_opts();
        opt_dly = -1; opt_spur = -1; opt_batt = -1; opt_en_drop = -1;
        opt_hold_idx = -1; opt_hold_edge = 0; opt_rst = -1;
    endtask

    task automatic wait_trmt(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (trmt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic quiet_until(input string tag, input int target);
        int seen;
        seen = 0;
        while (edge_cnt < target) begin
            @(negedge clk);
            if (trmt) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_trmt"}, trmt, 0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
    endtask

    task automatic run_packet(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                              input int exp_edge);
        logic [63:0] frame;
        bit          ok;
        int          hold_trmt;
        frame = {8'hAA, 8'h55, 4'h0, b[11:8], b[7:0], 4'h0, c[11:8], c[7:0], 4'h0, t[11:8], t[7:0]};
        wait_trmt(2 * PERIOD, ok);
        chk("first_trmt_seen", ok, 1);
        if (!ok) begin
            clear_opts();
            return;
        end
        chk("start_edge", edge_cnt, exp_edge);
        for (int i = 0; i < 8; i++) begin
            chk("byte", tx_data, frame[63-8*i -: 8]);
            chk("busy_in_pkt", busy, 1);
            if (i == opt_spur) begin
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                chk("spur_no_advance", trmt, 0);
                @(negedge clk);
                chk("spur_still_wait", {busy, trmt}, 2'b10);
            end else begin
                @(negedge clk);
                chk("trmt_single", trmt, 0);
            end
            if (i == opt_rst) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("async_rst");
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                clear_opts();
                return;
            end
            if (opt_dly > 0) repeat (opt_dly - 1) @(negedge clk);
            else             repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == opt_hold_idx) begin
                hold_trmt = 0;
                while (edge_cnt < opt_hold_edge) begin
                    @(negedge clk);
                    if (trmt) hold_trmt++;
                end
                chk("overrun_no_trmt", hold_trmt, 0);
            end
            chk("byte_stable", tx_data, frame[63-8*i -: 8]);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (i == opt_batt)    batt = 12'h555;
            if (i == opt_en_drop) en = 1'b0;
            if (i < 7) begin
                chk("next_trmt", trmt, 1);
            end else begin
                chk("pkt_done_pulse", {pkt_done, busy, trmt}, 3'b100);
                @(negedge clk);
                chk("pkt_done_single", pkt_done, 0);
            end
        end
        clear_opts();
    endtask

    initial begin
        logic [11:0] rc, rt, rb;
        clear_opts();
        rst = 1'b1; en = 1'b1; tx_done = 1'b0;
        batt = 12'hABC; curr = 12'h123; torque = 12'h7F0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // First packet, fixed responder latency, batt changes after byte 2.
        opt_dly = 3; opt_batt = 2;
        run_packet(12'hABC, 12'h123, 12'h7F0, PERIOD);

        // tx_done while idle must not start anything.
        repeat (5) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("idle_done_busy", {busy, trmt}, 2'b00);

        // Second packet carries the new battery value; spurious tx_done on byte 0.
        rc = 12'($urandom); rt = 12'($urandom);
        curr = rc; torque = rt;
        opt_spur = 0;
        run_packet(12'h555, rc, rt, 2 * PERIOD);

        // Enable low across a tick: no packet.
        en = 1'b0;
        quiet_until("en_low_quiet", 4 * PERIOD - 4);
        en = 1'b1;

        // Enable dropped after byte 1: packet completes, next tick is skipped.
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        opt_en_drop = 1;
        run_packet(rb, rc, rt, 4 * PERIOD);
        quiet_until("en_drop_quiet", 5 * PERIOD + 100);
        en = 1'b1;

        // Overrun: byte 3 held past the next tick.
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        opt_hold_idx = 3; opt_hold_edge = 7 * PERIOD + 5;
        run_packet(rb, rc, rt, 6 * PERIOD);
        batt = ~rb;

        // Next packet starts on the following tick, not the dropped one.
        run_packet(~rb, rc, rt, 8 * PERIOD);

        // Reset in WAIT at idx 4.
        rb = 12'($urandom); rc = 12'($urandom) | 12'h100; rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        opt_rst = 4;
        run_packet(rb, rc, rt, 9 * PERIOD);

        // After release the sequence restarts from AA one full period later.
        rb = 12'($urandom); rc = 12'($urandom); rt = 12'($urandom);
        batt = rb; curr = rc; torque = rt;
        run_packet(rb, rc, rt, PERIOD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
